// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the execute stage.
//   word_t      : 32-bit datapath word
//   aluop_t     : ALU operation select
//   muldiv_op_t : multiply/divide operation select (MULT, MULTU, DIV, DIVU)
// Helper functions classify a muldiv_op_t as divide and/or signed.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  function automatic logic md_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Port bundle for muldiv_unit, in the style of the ALU interface.
//   md : the unit's view (operands/controls in, status/results out)
//   tb : the requester's view (mirror of md)
// Optional macro MULDIV_DIVZERO_EN adds the divzero flag.
interface muldiv_if
  import cpu_types_pkg::*;
(
  input logic CLK,
  input logic nRST
);
  logic       start;
  muldiv_op_t op;
  word_t      PortA;
  word_t      PortB;
  logic       flush;
  logic       busy;
  logic       done;
  word_t      hi;
  word_t      lo;
`ifdef MULDIV_DIVZERO_EN
  logic       divzero;
`endif

  modport md (
    input  CLK, nRST, start, op, PortA, PortB, flush,
`ifdef MULDIV_DIVZERO_EN
    output divzero,
`endif
    output busy, done, hi, lo
  );

  modport tb (
    input  CLK, nRST, busy, done, hi, lo,
`ifdef MULDIV_DIVZERO_EN
    input  divzero,
`endif
    output start, op, PortA, PortB, flush
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Ports:
//   CLK, nRST     : clock (rising edge), async active-low reset
//   start, op     : request and operation; accepted in IDLE or DONE
//   PortA, PortB  : multiplicand/dividend, multiplier/divisor
//   flush         : abort, forces IDLE on the next edge
//   busy          : high while iterating (CALC)
//   done          : one-cycle pulse, hi/lo valid
//   hi, lo        : product [63:32]/[31:0], or remainder/quotient
//   divzero       : only with MULDIV_DIVZERO_EN; pulses with done on a
//                   short-circuited divide by zero (hi/lo left untouched)
// Macro MULDIV_DIVZERO_EN: divide by zero completes in one cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 shift-add / shift-subtract iterations, then one settle cycle
// SIGN  | sign fix-up of the raw result; hi/lo written on leaving
// DONE  | done pulse; may accept a back-to-back start
module muldiv_unit
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      PortA,
  input  word_t      PortB,
  input  logic       flush,
  output logic       busy,
  output logic       done,
`ifdef MULDIV_DIVZERO_EN
  output logic       divzero,
`endif
  output word_t      hi,
  output word_t      lo
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t     state, next_state;
  muldiv_op_t op_q;
  word_t      a_q, b_q;
  logic       sign_a, sign_b;
  logic [63:0] acc;
  logic [4:0] cnt;
  logic       calc_tc;

  logic       can_accept, accept, dz_accept;
  word_t      abs_a, abs_b;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] mul_step, div_step, prod;
  word_t      res_hi, res_lo;

  assign can_accept = start && ((state == IDLE) || (state == DONE));
  assign accept     = can_accept && !flush;

`ifdef MULDIV_DIVZERO_EN
  logic dz_q;
  assign dz_accept = can_accept && md_is_div(op) && (PortB == '0);
`else
  assign dz_accept = 1'b0;
`endif

  assign abs_a = (md_is_signed(op) && PortA[31]) ? -PortA : PortA;
  assign abs_b = (md_is_signed(op) && PortB[31]) ? -PortB : PortB;

  // Multiply: add multiplicand into the upper half when the LSB is set,
  // then shift right keeping the carry.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
  assign mul_step = {mul_sum, acc[31:1]};

  // Restoring divide: trial-subtract the divisor from the shifted partial
  // remainder; the remainder stays below the divisor, so bit 32 of the
  // difference is a clean borrow except for a zero divisor, which SIGN
  // overrides anyway.
  assign div_diff = acc[63:31] - {1'b0, b_q};
  assign div_step = div_diff[32] ? {acc[62:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = CALC;
      CALC: if (calc_tc) next_state = SIGN;
      SIGN: next_state = DONE;
      DONE: next_state = start ? CALC : IDLE;
    endcase
    if (dz_accept) next_state = DONE;
    if (flush)     next_state = IDLE;
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
`ifdef MULDIV_DIVZERO_EN
    divzero = (state == DONE) && dz_q;
`endif
  end

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (md_is_div(op_q)) begin
      if (b_q == '0) begin
        // a_q holds |PortA|; re-applying the sign restores the original word
        res_lo = '1;
        res_hi = sign_a ? -a_q : a_q;
      end else begin
        res_lo = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
        res_hi = sign_a ? -acc[63:32] : acc[63:32];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      calc_tc <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (accept) begin
        op_q    <= op;
        a_q     <= abs_a;
        b_q     <= abs_b;
        sign_a  <= md_is_signed(op) & PortA[31];
        sign_b  <= md_is_signed(op) & PortB[31];
        acc     <= md_is_div(op) ? {32'd0, abs_a} : {32'd0, abs_b};
        cnt     <= 5'd31;
        calc_tc <= 1'b0;
      end else if ((state == CALC) && !calc_tc) begin
        acc     <= md_is_div(op_q) ? div_step : mul_step;
        cnt     <= cnt - 5'd1;
        calc_tc <= (cnt == 5'd0);
      end
      if ((state == SIGN) && !flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

`ifdef MULDIV_DIVZERO_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) dz_q <= 1'b0;
    else       dz_q <= dz_accept && !flush;
  end
`endif

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the execute stage, alongside the ALU. It takes the same register operands as the ALU and performs MULT, MULTU, DIV and DIVU over multiple cycles. It holds the 64-bit result in HI/LO registers until the next operation completes. The hazard unit stalls the pipeline on `busy`, and the EX/MEM latch consumes `hi`/`lo` for MFHI/MFLO.

## Interface
Parameters:
- none (width is fixed at 32 by `cpu_types_pkg::word_t`)

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation; sampled on the clock edge.
- `op` in `muldiv_op_t` (2 bits): `MD_MULT`, `MD_MULTU`, `MD_DIV` or `MD_DIVU`.
- `PortA` in 32: multiplicand or dividend; captured when `start` is accepted.
- `PortB` in 32: multiplier or divisor; captured when `start` is accepted.
- `flush` in 1: abort the operation in flight (branch squash or exception).
- `busy` out 1: operation in progress; the pipeline stalls on it.
- `done` out 1: one-cycle pulse; `hi`/`lo` are updated in that cycle.
- `hi` out 32: product bits [63:32], or the remainder.
- `lo` out 32: product bits [31:0], or the quotient.
- `divzero` out 1: present only with `MULDIV_DIVZERO_EN`.

## Operation
- Reset values: FSM in `IDLE`; `busy=0`, `done=0`, `divzero=0`; `hi=0`, `lo=0`.
- FSM states and transitions:
  - `IDLE`: on `start`, go to `CALC`.
  - `CALC`: runs 32 iterations under a 5-bit down-counter from 31 to 0, then goes to `SIGN`.
  - `SIGN`: goes to `DONE`.
  - `DONE`: goes to `IDLE`, or to `CALC` if `start` is asserted.
- `start` is accepted only in `IDLE` or `DONE`, which allows back-to-back operations. `start` is ignored in `CALC` and `SIGN`.
- On accept, the unit latches `op`, the absolute values of `PortA`/`PortB` (signed ops only), and the two sign bits.
- `CALC`, multiply: shift-add over the 32 bits of a 64-bit accumulator.
- `CALC`, divide: restoring shift-subtract, giving a 32-bit remainder and a 32-bit quotient.
- `SIGN` stage:
  - Product is negated if signA≠signB (signed ops only).
  - Quotient is negated if signA≠signB.
  - Remainder takes the sign of the dividend.
- Arithmetic is modulo 2^32 per half; overflow is never flagged.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero (default build): `lo`=0xFFFFFFFF, `hi`=original `PortA`, regardless of signedness. This is a special case in `SIGN`.
- `hi`/`lo` are written only on entry to `DONE`; they hold their value otherwise, including across a flush.
- `flush` forces `IDLE` on the next edge from any state and wins over a simultaneous `start`. `hi`/`lo` are unchanged by a flush.
- `nRST` asserted mid-operation returns the unit to reset values immediately.

## Timing
- Edge 0: `start` is accepted.
- Edges 1–32: `CALC`.
- Edge 33: `SIGN`.
- Edge 34: `DONE`.
- `busy` is high during the cycles following edges 0–32 (33 cycles).
- `done` is high for exactly the one cycle following edge 34, with `hi`/`lo` valid.
- Latency is 34 cycles from accept to `done`.
- Back-to-back: `start` during `DONE` gives `busy=1` in the next cycle.
- `busy` is registered (derived from state); it is never a combinational function of `start`.

## Configuration
- `MULDIV_DIVZERO_EN` defined:
  - The `divzero` port exists.
  - DIV or DIVU with `PortB`=0 goes from accept straight to `DONE` (1-cycle latency, `busy` never high).
  - `divzero=1` together with `done`; `hi`/`lo` are unchanged.
- `MULDIV_DIVZERO_EN` undefined: no `divzero` port, and divide by zero takes the full 34 cycles with the default result above.

## Structure
- `muldiv_op_t` (2-bit enum) goes in `cpu_types_pkg`, next to `aluop_t`.
- The FSM state enum is local to the module.
- The ports are bundled in a new interface `muldiv_if`, with modports `md` and `tb`, in the style of the existing ALU interface.
- No sub-module: one FSM plus a shared 64-bit shift datapath in a single module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` 34 cycles after accept; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100 / 7 → `lo`=0xE, `hi`=0x2. Then a back-to-back `start` during `DONE` → `busy`=1 in the next cycle.
- Flush at cycle 10 of a MULT, with `start` high in the same cycle:
  - `busy`=0 in the next cycle and `done` is never pulsed.
  - `hi`/`lo` keep their prior values.
  - `nRST` mid-op gives all outputs 0.
- DIVU 5 / 0:
  - Default build: `lo`=0xFFFFFFFF, `hi`=5 at cycle 34.
  - With `MULDIV_DIVZERO_EN`: `done` and `divzero` at cycle 1, `hi`/`lo` unchanged.
